hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
Iterative multiply/divide unit that produces the HI/LO register write stream consumed by the write-back HI/LO register file. It accepts MULT/MULTU/DIV/DIVU operations from execute and holds `busy` high to stall the pipeline while it runs. On completion it emits a single-cycle paired HI/LO write: LO carries the low product word or the quotient, HI carries the high product word or the remainder. It sits between execute and write-back, driving the reg_hi_*/reg_lo_* write inputs.

Parameters:
DATA_WIDTH, 32, operand and HI/LO word width; the divider iteration count equals DATA_WIDTH.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset; reset asserted when reset = 0
start  in  1  launch request, sampled on rising edge
op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
operand_a  in  DATA_WIDTH  multiplicand / dividend (rs)
operand_b  in  DATA_WIDTH  multiplier / divisor (rt)
cancel  in  1  pipeline flush; abort current operation
busy  out  1  stall request, high whenever state != IDLE
div_by_zero  out  1  one-cycle flag, coincident with the write pulse of a zero-divisor DIV/DIVU
reg_hi_write_enable  out  1  one-cycle HI write strobe
reg_hi_write_data  out  DATA_WIDTH  HI write value
reg_lo_write_enable  out  1  one-cycle LO write strobe, always identical to reg_hi_write_enable
reg_lo_write_data  out  DATA_WIDTH  LO write value

Behaviour:
- States: IDLE, DIV, DONE. busy = (state != IDLE).
- Reset, asynchronous: state goes to IDLE immediately; every output goes to 0; the iteration counter and partial remainder/quotient are cleared. Reset mid-operation discards the operation and produces no write pulse.
- Accept: `start` is accepted only in IDLE with cancel = 0. Call this edge E0. `start` while busy is ignored and never queued.
- MULT/MULTU: at E0 the full 2*DATA_WIDTH product (signed or unsigned) is registered. HI = upper word, LO = lower word. State goes to DONE.
  - Write strobes are high for exactly the one cycle after E0; busy is high for that same single cycle.
- DIV/DIVU, divisor != 0:
  - At E0, operand magnitudes are loaded (absolute values for DIV; sign info stored) and the state goes to DIV with counter = 0.
  - Edges E1..E32: one restoring quotient bit per cycle.
  - At E32: sign fixup, results registered, state goes to DONE.
  - Strobes are high during the cycle after E32; state returns to IDLE at E33. busy is high for 33 cycles.
- Signed fixup:
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF yields LO = 0x80000000, HI = 0 (wraps, no trap).
- Divide by zero: completes like a multiply (DONE at E0) with HI = operand_a, LO = all-ones, div_by_zero = 1 for the strobe cycle.
- DONE always returns to IDLE on the next edge. A `start` in DONE is ignored.
- cancel = 1 in DIV or DONE forces IDLE on the next edge.
  - Strobes and div_by_zero are forced low combinationally in that cycle, so cancel takes priority over completion.
  - cancel with start in IDLE: start is ignored.
- Write data registers hold their last value after the strobe; only the enables return to 0.
- Operands are registered at E0; later changes to operand_a/operand_b do not affect the result.

Decomposition:
- Shared defines.v gains:
  - op encodings MULDIV_MULT/MULTU/DIV/DIVU;
  - RESET_ENABLE redefined as 1'b0 for active-low use;
  - existing WRITE_ENABLE reused for the strobes.
- Sub-module div_core: unsigned restoring divider.
  - Inputs: load, dividend, divisor.
  - Outputs: quotient, remainder, done after DATA_WIDTH cycles.
  - hilo_muldiv wraps div_core with sign handling, the multiply path and the FSM.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> one cycle after E0: both enables = 1 for one cycle, HI=0xFFFFFFFE, LO=0x00000001, busy high that cycle only.
- MULT a=0xFFFFFFFD (-3) b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7) b=2 -> busy high 33 cycles, strobe in cycle 33: LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=100 b=7 -> LO=14, HI=2. Second start pulses during busy are ignored, so exactly one write pulse occurs.
- DIV a=0x1234 b=0 -> next cycle: HI=0x1234, LO=0xFFFFFFFF, div_by_zero=1 for one cycle, busy one cycle.
- DIVU with cancel at the 10th busy cycle -> busy low next cycle, no strobe ever. Repeat with reset=0 mid-DIV -> all outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation encodings,
// FSM states, reset/strobe polarities and the default operand width.
package hilo_muldiv_pkg;

  localparam int unsigned MULDIV_DATA_WIDTH = 32;

  // Active-low reset level and write-strobe active level.
  localparam logic RESET_ENABLE = 1'b0;
  localparam logic WRITE_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    MULDIV_MULT  = 2'b00,
    MULDIV_MULTU = 2'b01,
    MULDIV_DIV   = 2'b10,
    MULDIV_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DIV  = 2'b01,
    ST_DONE = 2'b10
  } muldiv_state_e;

endpackage

// File: rtl/hilo_muldiv_if.sv
// Execute <-> multiply/divide unit bundle.
//   master: execute stage (drives start/op/operands/cancel, sees busy and the
//           HI/LO write stream); slave: hilo_muldiv.
interface hilo_muldiv_if
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MULDIV_DATA_WIDTH
) ();

  logic                  start;
  muldiv_op_e            op;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic                  cancel;
  logic                  busy;
  logic                  div_by_zero;
  logic                  reg_hi_write_enable;
  logic [DATA_WIDTH-1:0] reg_hi_write_data;
  logic                  reg_lo_write_enable;
  logic [DATA_WIDTH-1:0] reg_lo_write_data;

  modport master (
    output start, op, operand_a, operand_b, cancel,
    input  busy, div_by_zero,
    input  reg_hi_write_enable, reg_hi_write_data,
    input  reg_lo_write_enable, reg_lo_write_data
  );

  modport slave (
    input  start, op, operand_a, operand_b, cancel,
    output busy, div_by_zero,
    output reg_hi_write_enable, reg_hi_write_data,
    output reg_lo_write_enable, reg_lo_write_data
  );

endinterface

// File: rtl/hilo_muldiv_div_core.sv
// Unsigned restoring divider, one quotient bit per clock.
//   clock/reset : clock, async active-low reset
//   load        : capture dividend/divisor and start DATA_WIDTH iterations
//   abort       : stop an in-flight division
//   quotient_c / remainder_c : value produced by the current iteration
//   done_c      : high in the cycle whose iteration is the last one, so the
//                 caller can register the final result on that edge
module hilo_muldiv_div_core
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MULDIV_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient_c,
  output logic [DATA_WIDTH-1:0] remainder_c,
  output logic                  done_c
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] dvsr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  active_q;

  logic [DATA_WIDTH:0]   shifted_c;
  logic [DATA_WIDTH:0]   diff_c;
  logic                  fits_c;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted_c   = {rem_q, quo_q[DATA_WIDTH-1]};
    diff_c      = shifted_c - {1'b0, dvsr_q};
    fits_c      = ~diff_c[DATA_WIDTH];
    remainder_c = fits_c ? diff_c[DATA_WIDTH-1:0] : shifted_c[DATA_WIDTH-1:0];
    quotient_c  = {quo_q[DATA_WIDTH-2:0], fits_c};
    done_c      = active_q && (cnt_q == CNT_W'(DATA_WIDTH - 1));
  end

  // Iteration state; the quotient register doubles as the dividend shifter.
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      rem_q    <= '0;
      quo_q    <= dividend;
      dvsr_q   <= divisor;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (abort) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (active_q) begin
      rem_q <= remainder_c;
      quo_q <= quotient_c;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done_c) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit feeding the HI/LO register write port.
//   clock/reset : clock, async active-low reset
//   bus (slave) : start/op/operand_a/operand_b/cancel from execute;
//                 busy stall, div_by_zero flag and paired HI/LO write strobes
// Multiplies finish in one cycle; divides take DATA_WIDTH iterations in the
// div_core, with sign handling done here.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MULDIV_DATA_WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  hilo_muldiv_if.slave bus
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;

  muldiv_state_e         state_q;
  logic                  we_q;
  logic                  dbz_q;
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic                  neg_quo_q;
  logic                  neg_rem_q;

  logic                  accept_c;
  logic                  is_div_c;
  logic                  signed_c;
  logic                  a_neg_c;
  logic                  b_neg_c;
  logic                  b_zero_c;
  logic [DATA_WIDTH-1:0] a_mag_c;
  logic [DATA_WIDTH-1:0] b_mag_c;
  logic [PROD_W-1:0]     prod_s_c;
  logic [PROD_W-1:0]     prod_u_c;
  logic [DATA_WIDTH-1:0] quo_c;
  logic [DATA_WIDTH-1:0] rem_c;
  logic                  div_done_c;
  logic                  div_load_c;
  logic                  div_abort_c;

  // Operand decode, magnitudes and both products.
  always_comb begin
    accept_c    = (state_q == ST_IDLE) && bus.start && !bus.cancel;
    is_div_c    = bus.op[1];
    signed_c    = ~bus.op[0];
    a_neg_c     = signed_c & bus.operand_a[DATA_WIDTH-1];
    b_neg_c     = signed_c & bus.operand_b[DATA_WIDTH-1];
    b_zero_c    = (bus.operand_b == '0);
    a_mag_c     = a_neg_c ? -bus.operand_a : bus.operand_a;
    b_mag_c     = b_neg_c ? -bus.operand_b : bus.operand_b;
    prod_s_c    = {{DATA_WIDTH{bus.operand_a[DATA_WIDTH-1]}}, bus.operand_a} *
                  {{DATA_WIDTH{bus.operand_b[DATA_WIDTH-1]}}, bus.operand_b};
    prod_u_c    = {DATA_WIDTH'(0), bus.operand_a} * {DATA_WIDTH'(0), bus.operand_b};
    div_load_c  = accept_c && is_div_c && !b_zero_c;
    div_abort_c = (state_q == ST_DIV) && bus.cancel;
  end

  hilo_muldiv_div_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_div_core (
    .clock       (clock),
    .reset       (reset),
    .load        (div_load_c),
    .abort       (div_abort_c),
    .dividend    (a_mag_c),
    .divisor     (b_mag_c),
    .quotient_c  (quo_c),
    .remainder_c (rem_c),
    .done_c      (div_done_c)
  );

  // Control FSM and result registers; strobes default low every cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      we_q  <= ~WRITE_ENABLE;
      dbz_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            if (!is_div_c) begin
              {hi_q, lo_q} <= bus.op[0] ? prod_u_c : prod_s_c;
              we_q         <= WRITE_ENABLE;
              state_q      <= ST_DONE;
            end else if (b_zero_c) begin
              hi_q    <= bus.operand_a;
              lo_q    <= '1;
              dbz_q   <= 1'b1;
              we_q    <= WRITE_ENABLE;
              state_q <= ST_DONE;
            end else begin
              neg_quo_q <= a_neg_c ^ b_neg_c;
              neg_rem_q <= a_neg_c;
              state_q   <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          if (bus.cancel) begin
            state_q <= ST_IDLE;
          end else if (div_done_c) begin
            // Quotient negated on sign mismatch; remainder follows dividend.
            hi_q    <= neg_rem_q ? -rem_c : rem_c;
            lo_q    <= neg_quo_q ? -quo_c : quo_c;
            we_q    <= WRITE_ENABLE;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // cancel suppresses a completing write in the same cycle.
  assign bus.busy                = (state_q != ST_IDLE);
  assign bus.reg_hi_write_enable = we_q & ~bus.cancel;
  assign bus.reg_lo_write_enable = we_q & ~bus.cancel;
  assign bus.div_by_zero         = dbz_q & ~bus.cancel;
  assign bus.reg_hi_write_data   = hi_q;
  assign bus.reg_lo_write_data   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: vector table plus random operations
// scored through an expected-write queue, and hand sequences for cancel,
// start-while-busy and asynchronous reset.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  typedef struct {
    muldiv_op_e  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          busy_cycles;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   strobes = 0;
  exp_t exp_q[$];
  vec_t vecs[12];

  hilo_muldiv_if bus ();

  hilo_muldiv dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference built on the simulator's own arithmetic.
  function automatic exp_t model(input muldiv_op_e op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, q, r;
    logic [63:0] p, ua, ub, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    e.dbz = 1'b0;
    case (op)
      MULDIV_MULT:  begin p = 64'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; end
      MULDIV_MULTU: begin p = ua * ub;      e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 32'h0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else if (op == MULDIV_DIV) begin
          q = sa / sb; r = sa % sb;
          qv = 64'(q); rv = 64'(r);
          e.lo = qv[31:0]; e.hi = rv[31:0];
        end else begin
          qv = ua / ub; rv = ua % ub;
          e.lo = qv[31:0]; e.hi = rv[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Scoreboard: every write strobe pops and compares one expected record.
  always @(negedge clock) begin
    if (reset) begin
      if (bus.reg_hi_write_enable || bus.reg_lo_write_enable) begin
        exp_t e;
        strobes++;
        check("enable pair", 64'(bus.reg_lo_write_enable), 64'(bus.reg_hi_write_enable));
        check("busy at strobe", 64'(bus.busy), 64'(1));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected strobe: hi %h lo %h with nothing expected",
                   bus.reg_hi_write_data, bus.reg_lo_write_data);
        end else begin
          e = exp_q.pop_front();
          check("hi data", 64'(bus.reg_hi_write_data), 64'(e.hi));
          check("lo data", 64'(bus.reg_lo_write_data), 64'(e.lo));
          check("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
        end
      end else if (bus.div_by_zero) begin
        check("div_by_zero without strobe", 64'(bus.div_by_zero), 64'(0));
      end
    end
  end

  // Launch one op, scramble operands after acceptance, poke start mid-busy,
  // then check busy length, single strobe and held write data.
  task automatic run_op(input vec_t v);
    exp_t e;
    int   n;
    int   s0;
    s0 = strobes;
    e.hi = v.hi; e.lo = v.lo; e.dbz = v.dbz;
    exp_q.push_back(e);
    bus.op        = v.op;
    bus.operand_a = v.a;
    bus.operand_b = v.b;
    bus.start     = 1'b1;
    @(posedge clock); #1;
    bus.start     = 1'b0;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      bus.start = (n == 5);
      @(posedge clock); #1;
    end
    bus.start = 1'b0;
    check("busy cycles", 64'(n), 64'(v.busy_cycles));
    check("strobe count", 64'(strobes - s0), 64'(1));
    check("queue drained", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    check("hi held", 64'(bus.reg_hi_write_data), 64'(v.hi));
    check("lo held", 64'(bus.reg_lo_write_data), 64'(v.lo));
    check("enable idle", 64'(bus.reg_hi_write_enable), 64'(0));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    vec_t v;
    exp_t e;
    int   n;
    int   s0;

    vecs[0]  = '{MULDIV_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1};
    vecs[1]  = '{MULDIV_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1};
    vecs[2]  = '{MULDIV_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[3]  = '{MULDIV_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
    vecs[4]  = '{MULDIV_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33};
    vecs[5]  = '{MULDIV_DIV,   32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[6]  = '{MULDIV_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[7]  = '{MULDIV_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[8]  = '{MULDIV_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1};
    vecs[9]  = '{MULDIV_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 33};
    vecs[10] = '{MULDIV_DIVU,  32'h0000_0003, 32'h0000_000A, 32'h0000_0003, 32'h0000_0000, 1'b0, 33};
    vecs[11] = '{MULDIV_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};

    bus.start = 1'b0; bus.cancel = 1'b0; bus.op = MULDIV_MULT;
    bus.operand_a = '0; bus.operand_b = '0;

    // Reset state.
    #1;
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset hi we", 64'(bus.reg_hi_write_enable), 64'(0));
    check("reset hi data", 64'(bus.reg_hi_write_data), 64'(0));
    check("reset lo data", 64'(bus.reg_lo_write_data), 64'(0));
    check("reset dbz", 64'(bus.div_by_zero), 64'(0));
    @(posedge clock); #1;
    reset = 1'b1;
    idle_cycles(2);

    foreach (vecs[i]) run_op(vecs[i]);

    // Random operations against the reference model.
    for (int i = 0; i < 8; i++) begin
      v.op = muldiv_op_e'(2'($urandom_range(0, 3)));
      v.a  = $urandom;
      v.b  = (i == 3) ? 32'h0 : $urandom;
      e    = model(v.op, v.a, v.b);
      v.hi = e.hi; v.lo = e.lo; v.dbz = e.dbz;
      v.busy_cycles = (v.op[1] && v.b != 32'h0) ? 33 : 1;
      run_op(v);
    end

    // Cancel during the 10th busy cycle of a divide: no write, idle next cycle.
    s0 = strobes;
    bus.op = MULDIV_DIVU; bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      bus.cancel = (n == 10);
      @(posedge clock); #1;
    end
    bus.cancel = 1'b0;
    check("cancel busy cycles", 64'(n), 64'(10));
    idle_cycles(40);
    check("cancel no strobe", 64'(strobes - s0), 64'(0));

    // Cancel in the strobe cycle of a divide-by-zero suppresses the write.
    bus.op = MULDIV_DIV; bus.operand_a = 32'h55; bus.operand_b = 32'h0;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("dbz strobe before cancel", 64'(bus.reg_hi_write_enable), 64'(1));
    bus.cancel = 1'b1;
    #1;
    check("cancel kills hi we", 64'(bus.reg_hi_write_enable), 64'(0));
    check("cancel kills lo we", 64'(bus.reg_lo_write_enable), 64'(0));
    check("cancel kills dbz", 64'(bus.div_by_zero), 64'(0));
    @(posedge clock); #1;
    bus.cancel = 1'b0;
    check("idle after done cancel", 64'(bus.busy), 64'(0));

    // start together with cancel in IDLE is ignored.
    s0 = strobes;
    bus.op = MULDIV_MULTU; bus.operand_a = 32'd3; bus.operand_b = 32'd4;
    bus.start = 1'b1; bus.cancel = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.cancel = 1'b0;
    check("start+cancel ignored", 64'(bus.busy), 64'(0));
    idle_cycles(3);
    check("start+cancel no strobe", 64'(strobes - s0), 64'(0));

    // Asynchronous reset mid-divide clears outputs without a clock edge.
    s0 = strobes;
    bus.op = MULDIV_DIVU; bus.operand_a = 32'd12345; bus.operand_b = 32'd17;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    idle_cycles(5);
    #2;
    reset = 1'b0;
    #1;
    check("async rst busy", 64'(bus.busy), 64'(0));
    check("async rst hi we", 64'(bus.reg_hi_write_enable), 64'(0));
    check("async rst lo we", 64'(bus.reg_lo_write_enable), 64'(0));
    check("async rst hi data", 64'(bus.reg_hi_write_data), 64'(0));
    check("async rst lo data", 64'(bus.reg_lo_write_data), 64'(0));
    check("async rst dbz", 64'(bus.div_by_zero), 64'(0));
    @(posedge clock); #1;
    reset = 1'b1;
    idle_cycles(40);
    check("reset no strobe", 64'(strobes - s0), 64'(0));

    // Unit recovers after reset.
    run_op(vecs[4]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
